// File: rtl/wb_regfile_if.sv
// Writeback-stage register file bus: WB strobes and fields in, read ports and
// SP/OUT state back. The register file sits on the slave modport.
interface wb_regfile_if #(
   parameter int WIDTH = 8
);
   logic             write_en;
   logic             sw1;
   logic             sw2;
   logic             sp_inc;
   logic             sp_dec;
   logic             ld_out;
   logic [1:0]       ra_wb;
   logic [1:0]       rb_wb;
   logic [WIDTH-1:0] wb_data;
   logic [WIDTH-1:0] in_port;
   logic [1:0]       rd_addr_a;
   logic [1:0]       rd_addr_b;
   logic [WIDTH-1:0] rd_data_a;
   logic [WIDTH-1:0] rd_data_b;
   logic [WIDTH-1:0] sp_value;
   logic [WIDTH-1:0] out_port;
   // out_valid is a valid-only strobe with no ready: it is high for the cycle
   // after out_port is loaded, and the consumer must take out_port that cycle.
   logic             out_valid;

   modport master (
      output write_en, sw1, sw2, sp_inc, sp_dec, ld_out,
      output ra_wb, rb_wb, wb_data, in_port, rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b, sp_value, out_port, out_valid
   );

   modport slave (
      input  write_en, sw1, sw2, sp_inc, sp_dec, ld_out,
      input  ra_wb, rb_wb, wb_data, in_port, rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b, sp_value, out_port, out_valid
   );
endinterface

// File: rtl/wb_regfile.sv
// Four-entry register file with R3 as stack pointer, registered IN sample and
// OUT port. Define WB_RF_BYPASS_EN for write-through bypass on the read ports.
module wb_regfile #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] SP_RESET = 8'hFF
) (
   input  logic         clk,
   input  logic         rst_n,
   wb_regfile_if.slave  bus
);
   logic [WIDTH-1:0] regs_q [4];
   logic [WIDTH-1:0] regs_d [4];
   logic [WIDTH-1:0] in_q, in_d;
   logic [WIDTH-1:0] out_port_q, out_port_d;
   logic             out_valid_q, out_valid_d;

   logic [1:0]       dest;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] sp_next;
   logic [WIDTH-1:0] rd_a, rd_b;

   always_comb begin
      dest  = bus.sw1 ? bus.rb_wb : bus.ra_wb;
      wdata = bus.sw2 ? in_q : bus.wb_data;

      case ({bus.sp_inc, bus.sp_dec})
         2'b10:   sp_next = regs_q[3] + WIDTH'(1);
         2'b01:   sp_next = regs_q[3] - WIDTH'(1);
         default: sp_next = regs_q[3];
      endcase

      // SP step lands first so an explicit write to R3 overrides it.
      regs_d    = regs_q;
      regs_d[3] = sp_next;
      if (bus.write_en) begin
         regs_d[dest] = wdata;
      end

      in_d        = bus.in_port;
      out_port_d  = bus.ld_out ? regs_q[bus.rb_wb] : out_port_q;
      out_valid_d = bus.ld_out;
   end

`ifdef WB_RF_BYPASS_EN
   logic sp_active;

   always_comb begin
      sp_active = bus.sp_inc | bus.sp_dec;

      if (bus.write_en && (bus.rd_addr_a == dest)) begin
         rd_a = wdata;
      end else if ((bus.rd_addr_a == 2'd3) && sp_active) begin
         rd_a = sp_next;
      end else begin
         rd_a = regs_q[bus.rd_addr_a];
      end

      if (bus.write_en && (bus.rd_addr_b == dest)) begin
         rd_b = wdata;
      end else if ((bus.rd_addr_b == 2'd3) && sp_active) begin
         rd_b = sp_next;
      end else begin
         rd_b = regs_q[bus.rd_addr_b];
      end
   end
`else
   // Stored state only; decode must stall on a same-cycle WB register match.
   always_comb begin
      rd_a = regs_q[bus.rd_addr_a];
      rd_b = regs_q[bus.rd_addr_b];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q[0]   <= '0;
         regs_q[1]   <= '0;
         regs_q[2]   <= '0;
         regs_q[3]   <= SP_RESET;
         in_q        <= '0;
         out_port_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         in_q        <= in_d;
         out_port_q  <= out_port_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.rd_data_a = rd_a;
   assign bus.rd_data_b = rd_b;
   assign bus.sp_value  = regs_q[3];
   assign bus.out_port  = out_port_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Architectural register file and stack-pointer/output-port state for the writeback stage. Consumes the WB control strobes (`write_en`, `sw1`, `sw2`, `sp_inc`, `sp_dec`, `ld_out`) together with the WB instruction fields and data. Commits register writes, maintains R3 as the stack pointer, and drives the OUT port register. Provides two combinational read ports to the decode stage.

## Interface

Parameters:
- `WIDTH`, 8, data and register width
- `SP_RESET`, 8'hFF, reset value of R3 (SP)

Ports:
- `clk` in 1: system clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `write_en` in 1: commit a register write this cycle
- `sw1` in 1: destination select; 0 = `ra_wb`, 1 = `rb_wb`
- `sw2` in 1: data select; 0 = `wb_data`, 1 = `in_q` (registered IN port)
- `sp_inc` in 1: SP <- SP+1
- `sp_dec` in 1: SP <- SP-1
- `ld_out` in 1: load OUT port from R[`rb_wb`]
- `ra_wb` in 2: WB instruction ra field
- `rb_wb` in 2: WB instruction rb field
- `wb_data` in WIDTH: writeback data from MEM/ALU path
- `in_port` in WIDTH: external input port
- `rd_addr_a` in 2: read port A address
- `rd_addr_b` in 2: read port B address
- `rd_data_a` out WIDTH: read port A data, combinational
- `rd_data_b` out WIDTH: read port B data, combinational
- `sp_value` out WIDTH: current R3, registered
- `out_port` out WIDTH: OUT port register
- `out_valid` out 1: one-cycle pulse, high the cycle after `out_port` is loaded

## Operation

- Storage: R0..R3, WIDTH bits each. R3 is the SP.
- `in_q` samples `in_port` every cycle. IN data is therefore the port value from the previous edge.
- Write target `dest` = `sw1` ? `rb_wb` : `ra_wb`.
- Write data `wdata` = `sw2` ? `in_q` : `wb_data`.
- On a rising edge with `write_en`=1: R[`dest`] <= `wdata`.
- SP update applies on the same edge when no explicit write targets R3:
  - `sp_inc` only: R3 <= R3+1, mod 2^WIDTH. 8'hFF wraps to 8'h00.
  - `sp_dec` only: R3 <= R3-1, mod 2^WIDTH. 8'h00 wraps to 8'hFF.
  - Both high: R3 unchanged.
- If `write_en`=1 and `dest`=3, the explicit write wins and `sp_inc`/`sp_dec` are ignored that cycle. This covers POP R3 and IN R3.
- SP update and a write to R0..R2 in the same cycle are independent; both commit.
- OUT: when `ld_out`=1, `out_port` <= current stored R[`rb_wb`], read pre-edge. `out_valid` <= 1 for exactly one cycle; otherwise `out_valid` <= 0.
- Back-to-back `ld_out` keeps `out_valid` high continuously, with `out_port` updating each cycle.
- `write_en`, `sp_inc`, `sp_dec` and `ld_out` are all assumed mutually consistent from the WB decoder. No other combination checking is performed.
- Reads: `rd_data_x` = R[`rd_addr_x`], subject to the bypass described under Configuration.

## Timing

- Reset (async assert, synchronous-to-clk deassert by system):
  - R0, R1, R2 = 0; R3 = `SP_RESET`.
  - `in_q` = 0, `out_port` = 0, `out_valid` = 0.
  - `sp_value` = `SP_RESET`.
- Reset asserted mid-operation: all state returns to reset values immediately. A write pending on that edge is lost.
- Write latency: 1 edge. The value is visible on stored reads the cycle after `write_en`.
- SP latency: 1 edge to `sp_value`.
- IN path: `in_port` to register content takes 2 edges (sample into `in_q`, then write).
- OUT path: `ld_out` to `out_port`/`out_valid` takes 1 edge.
- Read ports are purely combinational from stored state, plus the bypass if compiled in. No clock on the read path.

## Configuration

- `WB_RF_BYPASS_EN` defined: write-through bypass on both read ports.
  - If `write_en`=1 and `rd_addr_x`=`dest`, `rd_data_x` = `wdata`.
  - Else if `rd_addr_x`=3 and an SP update is active this cycle, `rd_data_x` = the next SP value (R3±1, or R3 if both strobes are high).
  - `sp_value` stays registered and is not bypassed.
- Undefined: reads return stored state only. Upstream hazard logic must stall one cycle on a same-cycle WB/decode register match.

## Test plan

- Reset release:
  - `rd_addr_a`=0..3 -> 0, 0, 0, 8'hFF; `sp_value`=8'hFF; `out_valid`=0.
- Write and read:
  - `write_en`=1, `sw1`=0, `ra_wb`=1, `wb_data`=8'h5A -> next cycle R1=8'h5A.
  - With `WB_RF_BYPASS_EN` defined, `rd_data_a` (addr 1) = 8'h5A in the same cycle.
- SP wrap:
  - Three `sp_inc` from reset -> SP 8'h00, 8'h01, 8'h02.
  - Then `sp_inc`+`sp_dec` together -> SP stays 8'h02.
  - Then three `sp_dec` from 8'h02 -> 8'h01, 8'h00, 8'hFF.
- POP R3 priority:
  - `write_en`=1, `sw1`=1, `rb_wb`=3, `sp_inc`=1, `wb_data`=8'h40 -> R3=8'h40, not SP+1.
- IN/OUT:
  - `in_port`=8'hC3 held, IN with `rb_wb`=2 (`sw2`=1) -> R2=8'hC3.
  - Next cycle `ld_out` with `rb_wb`=2 -> `out_port`=8'hC3 and `out_valid` high for exactly 1 cycle.
- Async reset mid-write:
  - Assert `rst_n`=0 between edges while `write_en`=1 to R0 -> R0=0 and R3=8'hFF immediately.
  - No write committed on the following edge while reset is low.
